// File: rtl/noc_rf_pkg.sv
// Shared constants, write-port record and parity helper for the NoC PE register file.
package noc_rf_pkg;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_DEPTH_DEF  = 32;

    // Write records are sized for the widest supported configuration; users cast down.
    localparam int RF_DATA_W_MAX = 128;
    localparam int RF_ADDR_W_MAX = 16;

    typedef struct packed {
        logic                     en;
        logic [RF_ADDR_W_MAX-1:0] addr;
        logic [RF_DATA_W_MAX-1:0] data;
    } rf_wr_t;

    // Even parity: zero-extension of narrower words does not change the result.
    function automatic logic rf_parity(input logic [RF_DATA_W_MAX-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for pending long-latency writes: reserve sets, wp1 commit clears.
module rf_scoreboard #(
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [DEPTH-1:0]  busy_nxt,
    output logic [DEPTH-1:0]  busy_vec
);

    // A reservation landing in the same cycle as a clear wins: it is a newer request.
    always_comb begin
        busy_nxt = busy_vec;
        for (int i = 0; i < DEPTH; i++) begin
            if ((ZERO_REG != 0) && (i == 0))
                busy_nxt[i] = 1'b0;
            else if (rsv_en && (rsv_addr == ADDR_W'(i)))
                busy_nxt[i] = 1'b1;
            else if (clr_en && (clr_addr == ADDR_W'(i)))
                busy_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_vec <= '0;
        else
            busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a handshaked second write port, write-first bypass
// and busy scoreboard. Optional entry parity and rd_perr output under RF_PARITY_EN.
module regfile_mp_sb
    import noc_rf_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W_DEF,
    parameter  int DEPTH    = RF_DEPTH_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wp0_en,
    input  logic [ADDR_W-1:0]        wp0_addr,
    input  logic [DATA_W-1:0]        wp0_data,
    input  logic                     wp1_valid,
    output logic                     wp1_ready,
    input  logic [ADDR_W-1:0]        wp1_addr,
    input  logic [DATA_W-1:0]        wp1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
`ifdef RF_PARITY_EN
    output logic [NUM_RD-1:0]        rd_perr,
`endif
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0]        mem [DEPTH];
    rf_wr_t                   w0;
    rf_wr_t                   w1;
    logic                     w0_we;
    logic                     w1_we;
    logic [ADDR_W-1:0]        w0_a;
    logic [ADDR_W-1:0]        w1_a;
    logic [DATA_W-1:0]        w0_d;
    logic [DATA_W-1:0]        w1_d;
    logic [DEPTH-1:0]         busy_nxt;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
    logic [NUM_RD-1:0]        rd_busy_nxt;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // wp0 always wins an address collision; wp1 simply waits.
    assign wp1_ready = rst_n & ~(wp0_en & (wp0_addr == wp1_addr));

    always_comb begin
        w0      = '0;
        w0.en   = wp0_en;
        w0.addr = RF_ADDR_W_MAX'(wp0_addr);
        w0.data = RF_DATA_W_MAX'(wp0_data);
        w1      = '0;
        w1.en   = wp1_valid & wp1_ready;
        w1.addr = RF_ADDR_W_MAX'(wp1_addr);
        w1.data = RF_DATA_W_MAX'(wp1_data);
    end

    assign w0_a  = ADDR_W'(w0.addr);
    assign w1_a  = ADDR_W'(w1.addr);
    assign w0_d  = DATA_W'(w0.data);
    assign w1_d  = DATA_W'(w1.data);
    assign w0_we = w0.en & ~is_zero(w0_a);
    assign w1_we = w1.en & ~is_zero(w1_a);

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_en   (w1_we),
        .clr_addr (w1_a),
        .busy_nxt (busy_nxt),
        .busy_vec (busy_vec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (w0_we)
                mem[w0_a] <= w0_d;
            if (w1_we)
                mem[w1_a] <= w1_d;
        end
    end

`ifdef RF_PARITY_EN
    logic              par [DEPTH];
    logic [NUM_RD-1:0] rd_perr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                par[i] <= 1'b0;
        end else begin
            if (w0_we)
                par[w0_a] <= rf_parity(w0.data);
            if (w1_we)
                par[w1_a] <= rf_parity(w1.data);
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;

        assign ra   = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit0 = w0_we && (w0_a == ra);
        assign hit1 = w1_we && (w1_a == ra);

        assign rd_data_nxt[k*DATA_W +: DATA_W] = is_zero(ra) ? '0   :
                                                 hit0        ? w0_d :
                                                 hit1        ? w1_d : mem[ra];
        assign rd_busy_nxt[k] = busy_nxt[ra];
`ifdef RF_PARITY_EN
        // Bypassed data never touched the array, so there is nothing to check yet.
        assign rd_perr_nxt[k] = ~(hit0 | hit1) &
                                (rf_parity(RF_DATA_W_MAX'(mem[ra])) != par[ra]);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            rd_data <= rd_data_nxt;
            rd_busy <= rd_busy_nxt;
        end
    end

`ifdef RF_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_perr <= '0;
        else
            rd_perr <= rd_perr_nxt;
    end
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters); read results via a scoreboard queue.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wp0_en;
    logic [AW-1:0]    wp0_addr;
    logic [DW-1:0]    wp0_data;
    logic             wp1_valid;
    logic             wp1_ready;
    logic [AW-1:0]    wp1_addr;
    logic [DW-1:0]    wp1_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [DEPTH-1:0] busy_vec;
`ifdef RF_PARITY_EN
    logic [NR-1:0]    rd_perr;
`endif

    regfile_mp_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wp0_en    (wp0_en),
        .wp0_addr  (wp0_addr),
        .wp0_data  (wp0_data),
        .wp1_valid (wp1_valid),
        .wp1_ready (wp1_ready),
        .wp1_addr  (wp1_addr),
        .wp1_data  (wp1_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
`ifdef RF_PARITY_EN
        .rd_perr   (rd_perr),
`endif
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] mbusy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a read whose result must appear right after the next rising edge.
    task automatic expect_rd(input int port, input logic [AW-1:0] addr,
                             input logic [31:0] data, input logic busy);
        rd_exp_t e;
        rd_addr[port*AW +: AW] = addr;
        e.port = port;
        e.data = data;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            rd_exp_t e;
            e = exp_q.pop_front();
            check($sformatf("rd_data%0d", e.port), 64'(rd_data[e.port*DW +: DW]), 64'(e.data));
            check($sformatf("rd_busy%0d", e.port), 64'(rd_busy[e.port]), 64'(e.busy));
        end
    endtask

    task automatic idle();
        wp0_en    = 1'b0;
        wp1_valid = 1'b0;
        rsv_en    = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d);
        wp0_en   = 1'b1;
        wp0_addr = a;
        wp0_data = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [31:0] d);
        wp1_valid = 1'b1;
        wp1_addr  = a;
        wp1_data  = d;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    initial begin
        logic [31:0] v0;
        logic [31:0] v1;
        rst_n = 1'b0;
        rd_addr = '0;
        wp0_addr = '0;
        wp0_data = '0;
        wp1_addr = '0;
        wp1_data = '0;
        rsv_addr = '0;
        idle();

        // reset, wp1 must be refused while in reset
        wr1(5'd1, 32'h1);
        #1;
        check("wp1_ready_in_reset", 64'(wp1_ready), 64'd0);
        cyc();
        cyc();
        check("rd_data_reset", 64'(rd_data), 64'd0);
        check("rd_busy_reset", 64'(rd_busy), 64'd0);
        check("busy_vec_reset", 64'(busy_vec), 64'd0);
        idle();
        rst_n = 1'b1;

        // contents and activity in a reset cycle are wiped / discarded
        wr0(5'd5, 32'hDEADBEEF);
        cyc();
        idle();
        rst_n = 1'b0;
        wr0(5'd6, 32'h66);
        rsv(5'd6);
        wr1(5'd8, 32'h88);
        cyc();
        check("busy_vec_after_rst", 64'(busy_vec), 64'd0);
        check("rd_data_after_rst", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        idle();
        expect_rd(0, 5'd5, 32'h0, 1'b0);
        expect_rd(1, 5'd6, 32'h0, 1'b0);
        cyc();
        expect_rd(0, 5'd8, 32'h0, 1'b0);
        cyc();

        // write-first bypass
        wr0(5'd7, 32'h12345678);
        expect_rd(0, 5'd7, 32'h12345678, 1'b0);
        cyc();
        idle();

        // collision: wp0 wins, wp1 stalls then commits
        wr0(5'd3, 32'hA);
        wr1(5'd3, 32'hB);
        #1;
        check("wp1_ready_collision", 64'(wp1_ready), 64'd0);
        expect_rd(1, 5'd3, 32'hA, 1'b0);
        cyc();
        wp0_en = 1'b0;
        #1;
        check("wp1_ready_after_stall", 64'(wp1_ready), 64'd1);
        expect_rd(0, 5'd3, 32'hB, 1'b0);
        cyc();
        idle();
        expect_rd(0, 5'd3, 32'hB, 1'b0);
        cyc();

        // scoreboard: wp0 does not clear, wp1 does
        rsv(5'd9);
        cyc();
        idle();
        check("busy9_set", 64'(busy_vec[9]), 64'd1);
        wr0(5'd9, 32'h77);
        expect_rd(0, 5'd9, 32'h77, 1'b1);
        cyc();
        idle();
        check("busy9_after_wp0", 64'(busy_vec[9]), 64'd1);
        wr1(5'd9, 32'h55);
        expect_rd(0, 5'd9, 32'h55, 1'b0);
        cyc();
        idle();
        check("busy9_after_wp1", 64'(busy_vec[9]), 64'd0);
        expect_rd(1, 5'd9, 32'h55, 1'b0);
        cyc();

        // reserve and wp1 write in the same cycle: reservation wins, data lands
        rsv(5'd4);
        wr1(5'd4, 32'h44);
        expect_rd(1, 5'd4, 32'h44, 1'b1);
        cyc();
        idle();
        check("busy4_rsv_wins", 64'(busy_vec[4]), 64'd1);
        expect_rd(0, 5'd4, 32'h44, 1'b1);
        cyc();

        // register zero
        wr0(5'd0, 32'hFFFFFFFF);
        rsv(5'd0);
        expect_rd(0, 5'd0, 32'h0, 1'b0);
        cyc();
        idle();
        check("busy0", 64'(busy_vec[0]), 64'd0);
        wr1(5'd0, 32'hFFFF);
        #1;
        check("wp1_ready_r0", 64'(wp1_ready), 64'd1);
        expect_rd(1, 5'd0, 32'h0, 1'b0);
        cyc();
        idle();
        expect_rd(0, 5'd0, 32'h0, 1'b0);
        cyc();

        // both ports commit on distinct addresses
        wr0(5'd10, 32'h1010);
        wr1(5'd11, 32'h1111);
        #1;
        check("wp1_ready_dual", 64'(wp1_ready), 64'd1);
        cyc();
        idle();
        expect_rd(0, 5'd10, 32'h1010, 1'b0);
        expect_rd(1, 5'd11, 32'h1111, 1'b0);
        cyc();

        // model-based sweep: fill the whole file through both ports, read back
        mbusy = 32'h0000_0010;
        rsv(5'd20);
        cyc();
        idle();
        mbusy[20] = 1'b1;
        check("busy_vec_pre_sweep", 64'(busy_vec), 64'(mbusy));
        for (int i = 0; i < 16; i++) begin
            v0 = $urandom;
            v1 = $urandom;
            wr0(AW'(i), v0);
            wr1(AW'(i + 16), v1);
            #1;
            check($sformatf("wp1_ready_sweep%0d", i), 64'(wp1_ready), 64'd1);
            cyc();
            model[i]      = (i == 0) ? 32'h0 : v0;
            model[i + 16] = v1;
            mbusy[i + 16] = 1'b0;
        end
        idle();
        check("busy_vec_post_sweep", 64'(busy_vec), 64'(mbusy));
        for (int i = 0; i < 16; i++) begin
            expect_rd(0, AW'(i), model[i], mbusy[i]);
            expect_rd(1, AW'(31 - i), model[31 - i], mbusy[31 - i]);
            cyc();
        end

`ifdef RF_PARITY_EN
        rd_addr[0 +: AW] = 5'd2;
        rd_addr[AW +: AW] = 5'd3;
        cyc();
        check("perr_clean", 64'(rd_perr), 64'd0);
        dut.mem[2] = dut.mem[2] ^ 32'h1;
        cyc();
        check("perr_port0", 64'(rd_perr[0]), 64'd1);
        check("perr_port1", 64'(rd_perr[1]), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the NoC processing-element core.
- Replaces the fixed 32x32 two-read/one-write array.
- Adds:
  - configurable width, depth and read-port count
  - a second write port with valid/ready handshake, for load/packet returns
  - registered reads with write-first bypass
  - a per-register busy scoreboard for pending long-latency writes

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of two, >=2)
ADDR_W, $clog2(DEPTH), register index width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, if 1 register 0 reads as zero, ignores writes, never busy

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data
rd_busy  out  NUM_RD  registered busy flag of the addressed register
wp0_en  in  1  primary (ALU) write enable, always accepted
wp0_addr  in  ADDR_W  primary write index
wp0_data  in  DATA_W  primary write data
wp1_valid  in  1  secondary (load-return) write request
wp1_ready  out  1  secondary write accepted this cycle (combinational)
wp1_addr  in  ADDR_W  secondary write index
wp1_data  in  DATA_W  secondary write data
rsv_en  in  1  reserve request: mark register busy
rsv_addr  in  ADDR_W  register to reserve
busy_vec  out  DEPTH  current scoreboard, bit i = register i busy

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all registers cleared to 0; busy_vec=0
  - rd_data=0, rd_busy=0
  - wp1_ready forced 0 while rst_n=0
- Write ports:
  - wp0 commits when wp0_en=1.
  - wp1 commits when wp1_valid & wp1_ready.
  - wp1_ready = rst_n & ~(wp0_en & wp0_addr==wp1_addr).
  - On an address collision wp0 wins; wp1 stalls and must hold valid/addr/data stable until accepted.
  - Different addresses: both ports commit in the same cycle.
- Reads:
  - Latency 1: rd_addr is sampled at edge N; rd_data/rd_busy are valid after edge N.
  - Write-first bypass: a write committing at edge N to the sampled address appears in rd_data after edge N (wp0 data takes priority, though a collision cannot commit both).
  - Out-of-range addresses cannot occur because DEPTH is a power of two.
- Scoreboard, per register each cycle:
  - set if rsv_en & rsv_addr==i
  - else cleared if a write commits to i from wp1
  - wp0 writes do not clear busy
  - Reserve and wp1 write to the same register in the same cycle: busy stays 1 (new reservation wins); the data is still written.
  - rd_busy reflects the post-edge scoreboard (same write-first rule as data).
  - busy_vec is the registered scoreboard.
- ZERO_REG=1:
  - writes to index 0 are discarded; wp1 to index 0 is still accepted (ready rule unchanged)
  - rsv to 0 is ignored; busy_vec[0]=0; reads of 0 return 0, busy 0
- Reset mid-operation:
  - a write, reserve or pending wp1 in the reset cycle is discarded
  - the wp1 requester must re-present after reset

Optional Feature:
- Macro RF_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit computed on write
  - added output rd_perr (NUM_RD) is registered alongside rd_data; it is 1 if stored parity mismatches the stored data
  - bypassed data always reports 0
  - reset clears the parity bits
- When undefined: no parity storage and no rd_perr port.

Decomposition:
- Package noc_rf_pkg holds:
  - default DATA_W/DEPTH constants
  - the rf_wr_t struct (en, addr, data) used by both write ports internally
  - a function for parity
- One natural sub-module: rf_scoreboard (DEPTH busy bits, set/clear/priority logic, busy_vec output). The data array and read/bypass logic live in the top.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 one cycle, read r5 -> rd_data=0, busy_vec=0.
- Bypass: wp0 writes 0x12345678 to r7 while rd_addr port0=7 in the same cycle -> rd_data port0=0x12345678 after that edge.
- Collision: wp0_en and wp1_valid both to r3 (0xA, 0xB) -> wp1_ready=0, r3=0xA; next cycle with wp0_en=0 -> wp1 accepted, r3=0xB.
- Scoreboard: rsv r9, then wp0 write r9 -> busy_vec[9] stays 1; then wp1 write 0x55 to r9 -> busy_vec[9]=0, read r9=0x55.
- Simultaneous reserve and wp1 write to r4 -> r4 updated, busy_vec[4]=1.
- ZERO_REG: wp0 write 0xFFFFFFFF to r0 and rsv r0 -> read r0=0, busy_vec[0]=0. With RF_PARITY_EN defined, force a flipped data bit in r2 -> rd_perr=1 on its read port.
